// File: rtl/dbb_rd_dma_pkg.sv
// Shared types and constants for the DBB read DMA.
package dbb_rd_dma_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam int BLOCK_SIZE = 4096;
    localparam int MAX_BURST  = 16;

    // Burst length in beats: smallest of remaining beats, MAX_BURST and boundary room.
    function automatic logic [4:0] burst_min(input logic [15:0] rem, input logic [12:0] bnd);
        logic [15:0] m;
        m = 16'(MAX_BURST);
        if (rem < m) m = rem;
        if ({3'b0, bnd} < m) m = {3'b0, bnd};
        return 5'(m);
    endfunction

endpackage

// File: rtl/dbb_rd_dma_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on rd_data whenever count != 0.
module dbb_rd_dma_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_wr, do_rd;

    assign do_wr   = wr_en && (count != CW'(DEPTH));
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = (count != '0) ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/dbb_rd_dma.sv
// Read DMA: splits a linear request into AR bursts, buffers R data under a credit scheme.
// Define DBB_RD_DMA_4K_SPLIT_EN to keep bursts inside 4096-byte blocks.
module dbb_rd_dma
    import dbb_rd_dma_pkg::*;
#(
    parameter int         ADDR_WIDTH      = 32,
    parameter int         DATA_WIDTH      = 64,
    parameter int         FIFO_DEPTH      = 32,
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [7:0] AR_ID           = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_beats,
    output logic                  done,
    output logic                  err_rid,
    output logic                  ar_arvalid,
    input  logic                  ar_arready,
    output logic [ADDR_WIDTH-1:0] ar_araddr,
    output logic [3:0]            ar_arlen,
    output logic [7:0]            ar_arid,
    input  logic                  r_rvalid,
    output logic                  r_rready,
    input  logic                  r_rlast,
    input  logic [DATA_WIDTH-1:0] r_rdata,
    input  logic [7:0]            r_rid,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_n;
    logic [15:0]             rem, rem_n, tot, delivered;
    logic [CW-1:0]           credits, credits_n;
    logic [OW-1:0]           outst, outst_n;
    logic [4:0]              ar_len, len_n;
    logic [12:0]             bnd;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                    accept, ar_hs, r_hs, pop, issue_ok;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign ar_hs      = ar_arvalid && ar_arready;
    assign r_hs       = r_rvalid && r_rready;
    assign pop        = dout_valid && dout_ready;
    assign ar_arid    = AR_ID;
    assign ar_len     = {1'b0, ar_arlen} + 5'd1;
    assign dout_valid = (fifo_cnt != '0);
    assign dout_last  = dout_valid && (({1'b0, delivered} + 17'd1) == {1'b0, tot});

`ifdef DBB_RD_DMA_4K_SPLIT_EN
    assign bnd = (13'(BLOCK_SIZE) - {1'b0, cur_addr_n[11:0]}) >> OFFS;
`else
    assign bnd = 13'(MAX_BURST);
`endif
    assign len_n = burst_min(rem_n, bnd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Everything is evaluated on post-edge values so the AR register can reload
    // in the handshake cycle and keep bursts back-to-back.
    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        rem_n      = rem;
        case (state)
            IDLE: if (accept) begin
                cur_addr_n = req_addr & ~ADDR_WIDTH'(BYTES - 1);
                rem_n      = req_beats;
                state_n    = (req_beats == 16'd0) ? DRAIN : ISSUE;
            end
            ISSUE: if (ar_hs) begin
                cur_addr_n = cur_addr + (ADDR_WIDTH'(ar_len) << OFFS);
                rem_n      = rem - 16'(ar_len);
                if (rem == 16'(ar_len)) state_n = DRAIN;
            end
            DRAIN: if ((delivered + 16'(pop)) == tot) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        credits_n = credits - (ar_hs ? CW'(ar_len) : CW'(0)) + CW'(pop);
        outst_n   = outst + OW'(ar_hs) - OW'(r_hs && r_rlast);
        issue_ok  = (state_n == ISSUE) && (rem_n != 16'd0) &&
                    (credits_n >= CW'(len_n)) && (outst_n < OW'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr   <= '0;
            rem        <= '0;
            tot        <= '0;
            delivered  <= '0;
            credits    <= CW'(FIFO_DEPTH);
            outst      <= '0;
            ar_arvalid <= 1'b0;
            ar_araddr  <= '0;
            ar_arlen   <= '0;
            done       <= 1'b0;
            err_rid    <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            cur_addr <= cur_addr_n;
            rem      <= rem_n;
            credits  <= credits_n;
            outst    <= outst_n;
            r_rready <= 1'b1;
            done     <= (state == DRAIN) && (state_n == IDLE);
            if (!ar_arvalid || ar_arready) begin
                ar_arvalid <= issue_ok;
                if (issue_ok) begin
                    ar_araddr <= cur_addr_n;
                    ar_arlen  <= 4'(len_n - 5'd1);
                end
            end
            if (accept) begin
                tot       <= req_beats;
                delivered <= '0;
            end else if (pop) begin
                delivered <= delivered + 16'd1;
            end
            if (accept) err_rid <= 1'b0;
            if (r_hs && (r_rid != AR_ID)) err_rid <= 1'b1;
        end
    end

    dbb_rd_dma_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_hs),
        .wr_data (r_rdata),
        .rd_en   (dout_ready),
        .rd_data (dout_data),
        .count   (fifo_cnt)
    );

endmodule
